// File: rtl/maf_pkg.sv
// Shared encodings for the multiply-add alignment issue controller.
package maf_pkg;

   localparam logic [1:0] MODE_SGL  = 2'b00;
   localparam logic [1:0] MODE_DUAL = 2'b01;
   localparam logic [1:0] MODE_LOW  = 2'b10;
   localparam logic [1:0] MODE_ILL  = 2'b11;

   // Shift-register select that clears the alignment register; also the idle value.
   localparam logic [2:0] CONT_IDLE = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_SWITCH = 2'd3
   } maf_state_e;

   function automatic logic mode_legal(input logic [1:0] mode);
      return mode != MODE_ILL;
   endfunction

endpackage

// File: rtl/maf_issue_pipe.sv
// LAT-deep {valid, mode, tag} stage chain. The whole chain freezes while
// i_stall is high; i_clear empties it on the next edge and beats the stall.
module maf_issue_pipe
   import maf_pkg::*;
#(
   parameter int LAT   = 3,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_stall,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [1:0]       i_mode,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [1:0]       o_mode,
   output logic [TAG_W-1:0] o_tag
);

   logic [LAT-1:0]   r_vld;
   logic [1:0]       r_mode [LAT];
   logic [TAG_W-1:0] r_tag  [LAT];

   // Shift one stage per cycle unless stalled; clear drops every op in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_mode[i] <= MODE_SGL;
            r_tag[i]  <= '0;
         end
      end else if (i_clear) begin
         r_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_mode[i] <= MODE_SGL;
            r_tag[i]  <= '0;
         end
      end else if (!i_stall) begin
         r_vld[0]  <= i_valid;
         r_mode[0] <= i_mode;
         r_tag[0]  <= i_tag;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_mode[i] <= r_mode[i-1];
            r_tag[i]  <= r_tag[i-1];
         end
      end
   end

   assign o_valid = r_vld[LAT-1];
   assign o_mode  = r_mode[LAT-1];
   assign o_tag   = r_tag[LAT-1];

endmodule

// File: rtl/maf_mode_ctrl.sv
// Issue controller for the multi-precision multiply-add alignment datapath.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | pipeline empty, waiting for a request
//   ST_RUN    | issuing ops in cur_mode, results draining out
//   ST_DRAIN  | mode change pending, waiting for occ to reach 0
//   ST_SWITCH | one clear cycle, cur_mode takes the pending request mode
module maf_mode_ctrl
   import maf_pkg::*;
#(
   parameter int LAT   = 3,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_mode,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic [2:0]       cont,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_mode,
   output logic [TAG_W-1:0] res_tag,
   output logic             err,
   output logic             busy
);

   localparam int OCC_W = $clog2(LAT + 1);

   maf_state_e       r_state;
   maf_state_e       w_state_nxt;
   logic [1:0]       r_cur_mode;
   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] w_occ_nxt;
   logic             r_err;

   logic w_stall;
   logic w_legal;
   logic w_same;
   logic w_mode_diff;
   logic w_acc_legal;
   logic w_res_hs;
   logic w_mode_load;

   assign w_stall     = res_valid && !res_ready;
   assign w_legal     = mode_legal(req_mode);
   assign w_same      = req_mode == r_cur_mode;
   assign w_mode_diff = req_valid && w_legal && !w_same;
   assign w_acc_legal = req_ready && w_legal;
   assign w_res_hs    = res_valid && res_ready;

   // Occupancy tracks valid pipeline stages; accept and delivery in one cycle cancel.
   always_comb begin
      w_occ_nxt = r_occ;
      if (flush) begin
         w_occ_nxt = '0;
      end else if (w_acc_legal && !w_res_hs) begin
         w_occ_nxt = r_occ + OCC_W'(1);
      end else if (!w_acc_legal && w_res_hs) begin
         w_occ_nxt = r_occ - OCC_W'(1);
      end
   end

   // Next-state decode plus the combinational handshake/cont/busy outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_load = 1'b0;
      req_ready   = 1'b0;
      cont        = CONT_IDLE;
      busy        = (r_state != ST_IDLE) || (r_occ != '0);

      // Illegal-mode requests are swallowed wherever a same-mode one would be.
      if (!flush && !w_stall && req_valid && (w_same || !w_legal) &&
          ((r_state == ST_IDLE) || (r_state == ST_RUN))) begin
         req_ready = 1'b1;
      end
      if (req_ready && w_legal) begin
         cont = {1'b0, req_mode};
      end

      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_mode_diff) begin
                  w_state_nxt = ST_SWITCH;
               end else if (req_ready && w_legal) begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_mode_diff) begin
                  w_state_nxt = ST_DRAIN;
               end else if (!req_valid && (w_occ_nxt == '0)) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (r_occ == '0) begin
                  w_state_nxt = ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               w_mode_load = req_valid && w_legal;
               w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Current precision mode, occupancy and the illegal-request error pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cur_mode <= MODE_SGL;
         r_occ      <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_mode_load) begin
            r_cur_mode <= req_mode;
         end
         r_occ <= w_occ_nxt;
         r_err <= req_ready && !w_legal;
      end
   end

   assign err = r_err;

   maf_issue_pipe #(
      .LAT   (LAT),
      .TAG_W (TAG_W)
   ) u_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .i_stall (w_stall),
      .i_clear (flush),
      .i_valid (w_acc_legal),
      .i_mode  (req_mode),
      .i_tag   (req_tag),
      .o_valid (res_valid),
      .o_mode  (res_mode),
      .o_tag   (res_tag)
   );

endmodule

// File: tb/tb_maf_mode_ctrl.sv
// Directed bench for maf_mode_ctrl with LAT = 3, TAG_W = 4.
module tb_maf_mode_ctrl;

   localparam int LAT   = 3;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_mode = 2'b00;
   logic [TAG_W-1:0] req_tag = '0;
   logic             flush = 1'b0;
   logic [2:0]       cont;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [1:0]       res_mode;
   logic [TAG_W-1:0] res_tag;
   logic             err;
   logic             busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   maf_mode_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_tag   (req_tag),
      .flush     (flush),
      .cont      (cont),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_mode  (res_mode),
      .res_tag   (res_tag),
      .err       (err),
      .busy      (busy)
   );

   typedef struct {
      logic       v;
      logic [1:0] m;
      logic [3:0] t;
      logic       f;
      logic       rr;
      logic       rdy;
      logic [2:0] cont;
      logic       rv;
      logic [1:0] rm;
      logic [3:0] rt;
      logic       err;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic v, input logic [1:0] m, input logic [3:0] t,
                               input logic f, input logic rr, input logic rdy,
                               input logic [2:0] c, input logic rv, input logic [1:0] rm,
                               input logic [3:0] rt, input logic e, input logic b);
      vec_t x;
      x.v = v; x.m = m; x.t = t; x.f = f; x.rr = rr;
      x.rdy = rdy; x.cont = c; x.rv = rv; x.rm = rm; x.rt = rt; x.err = e; x.busy = b;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1: drive inputs, check at the falling edge, return at next posedge+1.
   task automatic step(input vec_t x, input string lbl);
      req_valid = x.v;
      req_mode  = x.m;
      req_tag   = x.t;
      flush     = x.f;
      res_ready = x.rr;
      @(negedge clk);
      chk({lbl, ".req_ready"}, req_ready, x.rdy);
      chk({lbl, ".cont"},      cont,      x.cont);
      chk({lbl, ".res_valid"}, res_valid, x.rv);
      chk({lbl, ".err"},       err,       x.err);
      chk({lbl, ".busy"},      busy,      x.busy);
      if (x.rv) begin
         chk({lbl, ".res_mode"}, res_mode, x.rm);
         chk({lbl, ".res_tag"},  res_tag,  x.rt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string lbl);
      chk({lbl, ".req_ready"}, req_ready, 1'b0);
      chk({lbl, ".cont"},      cont,      3'b011);
      chk({lbl, ".res_valid"}, res_valid, 1'b0);
      chk({lbl, ".res_mode"},  res_mode,  2'b00);
      chk({lbl, ".res_tag"},   res_tag,   4'h0);
      chk({lbl, ".err"},       err,       1'b0);
      chk({lbl, ".busy"},      busy,      1'b0);
   endtask

   initial begin
      // args: v m t f rr | rdy cont rv rm rt err busy
      // back-to-back mode 00, tags 0..5
      tbl.push_back(mk(1,0,0,0,1, 1,3'b000,0,0,0,0,0));
      tbl.push_back(mk(1,0,1,0,1, 1,3'b000,0,0,0,0,1));
      tbl.push_back(mk(1,0,2,0,1, 1,3'b000,0,0,0,0,1));
      tbl.push_back(mk(1,0,3,0,1, 1,3'b000,1,0,0,0,1));
      tbl.push_back(mk(1,0,4,0,1, 1,3'b000,1,0,1,0,1));
      tbl.push_back(mk(1,0,5,0,1, 1,3'b000,1,0,2,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,0,3,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,0,4,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,0,5,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,0));
      // mode change 00 -> 01
      tbl.push_back(mk(1,0,1,0,1, 1,3'b000,0,0,0,0,0));
      tbl.push_back(mk(1,0,2,0,1, 1,3'b000,0,0,0,0,1));
      tbl.push_back(mk(1,1,3,0,1, 0,3'b011,0,0,0,0,1));
      tbl.push_back(mk(1,1,3,0,1, 0,3'b011,1,0,1,0,1));
      tbl.push_back(mk(1,1,3,0,1, 0,3'b011,1,0,2,0,1));
      tbl.push_back(mk(1,1,3,0,1, 0,3'b011,0,0,0,0,1));
      tbl.push_back(mk(1,1,3,0,1, 0,3'b011,0,0,0,0,1));
      tbl.push_back(mk(1,1,3,0,1, 1,3'b001,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,1,3,0,1));
      // backpressure: 3 ops in mode 01, then 4 stall cycles with a request pending
      tbl.push_back(mk(1,1,4,0,1, 1,3'b001,0,0,0,0,0));
      tbl.push_back(mk(1,1,5,0,1, 1,3'b001,0,0,0,0,1));
      tbl.push_back(mk(1,1,6,0,1, 1,3'b001,0,0,0,0,1));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1,1,8,0,0, 0,3'b011,1,1,4,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,1,4,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,1,5,0,1));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,1,1,6,0,1));
      // illegal mode 11, tag 7
      tbl.push_back(mk(1,3,7,0,1, 1,3'b011,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,0));

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // flush with two ops in flight and a same-mode (01) request pending
      step(mk(1,1,9, 0,1, 1,3'b001,0,0,0,0,0), "fl0");
      step(mk(1,1,10,0,1, 1,3'b001,0,0,0,0,1), "fl1");
      step(mk(1,1,11,1,1, 0,3'b011,0,0,0,0,1), "fl2");
      step(mk(0,0,0, 0,1, 0,3'b011,0,0,0,0,0), "fl3");
      step(mk(1,1,12,0,1, 1,3'b001,0,0,0,0,0), "fl4");
      step(mk(0,0,0, 0,1, 0,3'b011,0,0,0,0,1), "fl5");
      step(mk(0,0,0, 0,1, 0,3'b011,0,0,0,0,1), "fl6");
      step(mk(0,0,0, 0,1, 0,3'b011,1,1,12,0,1), "fl7");
      step(mk(0,0,0, 0,1, 0,3'b011,0,0,0,0,0), "fl8");

      // reset mid-flight: three mode-01 ops, then asynchronous reset
      step(mk(1,1,1,0,1, 1,3'b001,0,0,0,0,0), "rs0");
      step(mk(1,1,2,0,1, 1,3'b001,0,0,0,0,1), "rs1");
      step(mk(1,1,3,0,1, 1,3'b001,0,0,0,0,1), "rs2");
      req_valid = 1'b0;
      res_ready = 1'b0;
      #2;
      chk("rs3.res_valid_before", res_valid, 1'b1);
      chk("rs3.res_tag_before",   res_tag,   4'h1);
      rstn = 1'b0;
      #1;
      chk_reset_vals("rs_async");
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rs_hold");
      rstn = 1'b1;
      res_ready = 1'b1;
      // cur_mode is back to 00, so a mode-00 request goes straight through
      step(mk(1,0,5,0,1, 1,3'b000,0,0,0,0,0), "po0");
      step(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,1), "po1");
      step(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,1), "po2");
      step(mk(0,0,0,0,1, 0,3'b011,1,0,5,0,1), "po3");
      step(mk(0,0,0,0,1, 0,3'b011,0,0,0,0,0), "po4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maf_mode_ctrl.md
# maf_mode_ctrl

Issue controller for the multi-precision multiply-add alignment datapath. It accepts operation requests over a valid/ready handshake and drives the 3-bit `cont` mode select of the alignment shift register. It tracks in-flight operations through a fixed-latency pipeline and returns each op's tag and mode with backpressure. A precision-mode change is serialised: the controller drains the pipeline, then spends one clear cycle before it issues in the new mode.

## Interface
- `LAT`, default 3: cycles from request acceptance to result valid; legal range 1..8.
- `TAG_W`, default 4: width of the request/result tag.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_mode`  in  2  precision mode:
  - 00: single 24-bit mantissa
  - 01: dual 11-bit halves
  - 10: single with low-aligned packing
  - 11: illegal
- `req_tag`  in  TAG_W  opaque id, returned with the result.
- `flush`  in  1  synchronous abort of all in-flight ops.
- `cont`  out  3  shift-register mode select.
- `res_valid`  out  1  result slot occupied.
- `res_ready`  in  1  consumer takes the result.
- `res_mode`  out  2  mode of the op in the result slot.
- `res_tag`  out  TAG_W  tag of the op in the result slot.
- `err`  out  1  one-cycle pulse after an illegal-mode request is accepted.
- `busy`  out  1  high when state is not IDLE or any op is in flight.

## Operation
- FSM states: IDLE, RUN, DRAIN, SWITCH. The controller also holds registered `cur_mode` (reset value 00) and an occupancy counter `occ` (0..LAT).
- **IDLE** (pipeline empty):
  - Legal request with `req_mode == cur_mode`: accept and go to RUN.
  - Legal request with a different mode: `req_ready` stays 0; go to SWITCH.
- **RUN**:
  - Same-mode legal request: accept while not stalled.
  - Different mode: `req_ready` 0; go to DRAIN.
  - No request and `occ` reaching 0: go to IDLE.
- **DRAIN**: `req_ready` 0. When `occ` is 0, go to SWITCH.
- **SWITCH**: one cycle. `cont` = 3'b011 (clears the shift register), `cur_mode` ← `req_mode`, then go to RUN.
- Illegal mode (11):
  - Accepted whenever `req_ready` would be high for a same-mode request, regardless of `cur_mode`.
  - Not entered into the pipeline; `err` = 1 in the next cycle.
  - `cont` stays 3'b011.
- `cont` is `{1'b0, req_mode}` in a cycle where a legal request is accepted, otherwise 3'b011.
- Pipeline: LAT stages, each holding {valid, mode, tag}. Stage LAT drives `res_*`.
- Stall: `res_valid && !res_ready` freezes every stage and forces `req_ready` to 0.
- `occ` counts valid stages: +1 on legal accept, −1 on result handshake, unchanged when both happen in the same cycle.
- `flush` has priority over everything else:
  - `req_ready` is 0 in the flush cycle.
  - Next cycle: all stages invalid, `occ` = 0, state IDLE, `cur_mode` unchanged.

## Timing
- Reset values:
  - `req_ready` 0
  - `cont` 3'b011
  - `res_valid` 0
  - `res_mode` 00
  - `res_tag` 0
  - `err` 0
  - `busy` 0
- `req_ready`, `cont` and `busy` are combinational from state, `occ`, the stall condition and the request. All other outputs are registered.
- Latency: a legal accept in cycle t gives `res_valid` in cycle t+LAT with no stall. Each stall cycle adds 1.
- Throughput: 1 op/cycle within one mode.
- Mode change cost: drain cycles (up to LAT), plus 1 SWITCH cycle, before the first new-mode accept.
- Result handshake and a new accept in the same cycle are both legal; this is the full-throughput case.
- Reset asserted mid-operation: all in-flight ops are lost; the block returns to the reset values immediately (asynchronously).

## Structure
- Shared package `maf_pkg`:
  - mode encodings `MODE_SGL` = 2'b00, `MODE_DUAL` = 2'b01, `MODE_LOW` = 2'b10, `MODE_ILL` = 2'b11
  - `CONT_IDLE` = 3'b011
  - FSM state enum
- One sub-module: `maf_issue_pipe`, the LAT-deep {valid, mode, tag} stage chain with a global stall enable and a synchronous clear.
- FSM, `occ` counter and `cont` decode stay in the top level.

## Test plan
- **Back-to-back same mode** (LAT = 3): 6 mode-00 requests, tags 0..5, with `res_ready` held 1.
  - `cont` = 000 in each accept cycle.
  - `res_valid` from cycle 3 to cycle 8, tags in order.
  - `busy` falls after the last result.
- **Mode change**: mode 00 tags 1–2, then mode 01 tag 3.
  - `req_ready` stays 0 until `occ` = 0.
  - One SWITCH cycle with `cont` = 011.
  - Tag 3 accepted with `cont` = 001; `res_mode` = 01.
- **Backpressure**: `res_ready` = 0 for 4 cycles while 3 ops are in flight.
  - Result slot holds the same tag.
  - `req_ready` = 0 during the stall.
  - All 3 ops delivered in order after release.
- **Illegal mode**: request with mode 11, tag 7.
  - Accepted; `err` pulses one cycle later.
  - No `res_valid` for tag 7; `cont` stays 011.
- **Flush**: `flush` asserted with 2 ops in flight and a same-mode request pending.
  - `req_ready` 0 in that cycle.
  - Next cycle `res_valid` = 0, `occ` = 0, state IDLE.
  - A later mode-`cur_mode` request is accepted immediately.
- **Reset mid-flight**: drop `rstn` while 3 ops are in flight.
  - Outputs go to their reset values immediately.
  - After release, the first mode-00 request is accepted with no SWITCH cycle.
